// File: rtl/spi_frame_sender.sv
// -----------------------------------------------------------------------------
// spi_frame_sender
//
// Streams one full framebuffer image out over a mode-0 SPI link on request.
// A frame is two ss transactions:
//   1) command byte 0xF0 followed by every framebuffer word, row outer /
//      column inner, each word most significant byte first;
//   2) after an ss-low gap of 4*clk_div cycles, the single command byte 0x10.
// Words are fetched one at a time through a one-cycle-latency read port.
//
// Parameters
//   segments  display segments per column word (word = segments*3 bytes)
//   rows      addressable rows
//   columns   columns per row
//   bitwidth  bits per colour channel (only 8 is supported)
//   clk_div   sclk half-period in clk cycles (>= 1)
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   start  in   one-cycle request to send a frame (ignored while busy)
//   busy   out  frame in progress
//   done   out  one-cycle pulse at frame completion
//   ren    out  framebuffer read strobe
//   rrow   out  read row address
//   rcol   out  read column address
//   rdata  in   read data, valid one clk after ren
//   sclk   out  SPI clock, idle low
//   ss     out  slave select, active-high
//   mosi   out  serial data, MSB first
//   miso   in   unused
// -----------------------------------------------------------------------------
module spi_frame_sender #(
    parameter int segments = 1,
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int bitwidth = 8,
    parameter int clk_div  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            ren,
    output logic [$clog2(rows)-1:0]         rrow,
    output logic [$clog2(columns)-1:0]      rcol,
    input  logic [segments*bitwidth*3-1:0]  rdata,
    output logic                            sclk,
    output logic                            ss,
    output logic                            mosi,
    input  logic                            miso
);

    localparam int WORD_W = segments * bitwidth * 3;
    localparam int BYTES  = segments * 3;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W  = $clog2(4 * clk_div);
    localparam int ROW_W  = $clog2(rows);
    localparam int COL_W  = $clog2(columns);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_CMD = 3'd1;
    localparam logic [2:0] S_FETCH    = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_END_CMD  = 3'd5;
    localparam logic [2:0] S_FINISH   = 3'd6;

    // What the byte currently in SEND belongs to.
    localparam logic [1:0] K_START = 2'd0;
    localparam logic [1:0] K_DATA  = 2'd1;
    localparam logic [1:0] K_END   = 2'd2;

    localparam logic [7:0] CMD_START = 8'hF0;
    localparam logic [7:0] CMD_END   = 8'h10;

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(clk_div - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(4 * clk_div - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(rows - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(columns - 1);

    logic [2:0]        r_state;
    logic [1:0]        r_kind;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit;
    logic [BYTE_W-1:0] r_byte;
    logic [WORD_W-1:0] r_word;

    logic w_half_end;
    logic w_last_word;
    logic w_unused;

    assign w_half_end  = (r_cnt == HALF_LAST);
    assign w_last_word = (rrow == ROW_LAST) && (rcol == COL_LAST);

    // The shift word is shifted left on every sclk fall, so its top bit is
    // always the bit on the wire. It drains to zero after the last bit,
    // which keeps mosi low whenever nothing is being sent.
    assign mosi     = r_word[WORD_W-1];
    assign w_unused = miso;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_kind  <= K_START;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_word  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ren     <= 1'b0;
            rrow    <= '0;
            rcol    <= '0;
            sclk    <= 1'b0;
            ss      <= 1'b0;
        end else begin
            done <= 1'b0;
            ren  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD_CMD;
                        r_kind  <= K_START;
                        busy    <= 1'b1;
                        ss      <= 1'b1;
                        r_word  <= {CMD_START, {(WORD_W-8){1'b0}}};
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_byte  <= '0;
                    end
                end

                // ss is already high and the command MSB is on mosi; hold
                // sclk low for one half-period before the first rise.
                S_LOAD_CMD, S_END_CMD: begin
                    if (w_half_end) begin
                        r_cnt   <= '0;
                        sclk    <= 1'b1;
                        r_state <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // cnt 0: ren visible with address; cnt 1: rdata valid, latch;
                // cnt 2: mosi has settled, raise sclk for the first bit.
                S_FETCH: begin
                    if (r_cnt == '0) begin
                        r_cnt <= CNT_W'(1);
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_word <= rdata;
                        r_cnt  <= CNT_W'(2);
                    end else begin
                        r_cnt   <= '0;
                        sclk    <= 1'b1;
                        r_state <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (!w_half_end) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (sclk) begin
                            sclk   <= 1'b0;
                            r_word <= r_word << 1;
                        end else if (r_bit != 3'd7) begin
                            r_bit <= r_bit + 1'b1;
                            sclk  <= 1'b1;
                        end else begin
                            // Low half of bit 7 finished: the byte is complete.
                            r_bit <= '0;
                            case (r_kind)
                                K_START: begin
                                    r_kind  <= K_DATA;
                                    r_byte  <= '0;
                                    ren     <= 1'b1;
                                    r_state <= S_FETCH;
                                end
                                K_DATA: begin
                                    if (r_byte != BYTE_LAST) begin
                                        r_byte <= r_byte + 1'b1;
                                        sclk   <= 1'b1;
                                    end else if (w_last_word) begin
                                        r_byte  <= '0;
                                        rrow    <= '0;
                                        rcol    <= '0;
                                        ss      <= 1'b0;
                                        r_state <= S_GAP;
                                    end else begin
                                        r_byte <= '0;
                                        if (rcol == COL_LAST) begin
                                            rcol <= '0;
                                            rrow <= rrow + 1'b1;
                                        end else begin
                                            rcol <= rcol + 1'b1;
                                        end
                                        ren     <= 1'b1;
                                        r_state <= S_FETCH;
                                    end
                                end
                                default: begin
                                    ss      <= 1'b0;
                                    done    <= 1'b1;
                                    r_state <= S_FINISH;
                                end
                            endcase
                        end
                    end
                end

                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        ss      <= 1'b1;
                        r_kind  <= K_END;
                        r_word  <= {CMD_END, {(WORD_W-8){1'b0}}};
                        r_state <= S_END_CMD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_FINISH: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_frame_sender.md
SPI_FRAME_SENDER -- requirements
Module: spi_frame_sender

Interface
REQ-001 SHALL have parameter segments, default 1, number of display segments per column word.
REQ-002 SHALL have parameter rows, default 8, number of addressable rows.
REQ-003 SHALL have parameter columns, default 32, number of columns per row.
REQ-004 SHALL have parameter bitwidth, default 8, bits per colour channel; only 8 is supported.
REQ-005 SHALL have parameter clk_div, default 2, sclk half-period in clk cycles; minimum 1.
REQ-006 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  input  1  one-cycle request to send one full frame.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the frame completes.
REQ-011 SHALL have port ren  output  1  framebuffer read strobe.
REQ-012 SHALL have port rrow  output  $clog2(rows)  read row address.
REQ-013 SHALL have port rcol  output  $clog2(columns)  read column address.
REQ-014 SHALL have port rdata  input  segments*bitwidth*3  read data, valid exactly 1 clk after ren.
REQ-015 SHALL have port sclk  output  1  SPI clock, idle low (mode 0).
REQ-016 SHALL have port ss  output  1  slave select, active-high, low when idle.
REQ-017 SHALL have port mosi  output  1  serial data, MSB first.
REQ-018 SHALL have port miso  input  1  ignored.

Function
REQ-019 SHALL implement states IDLE, LOAD_CMD, FETCH, SEND, GAP, END_CMD, FINISH.
REQ-020 SHALL leave IDLE on start=1 only; start while busy=1 SHALL be ignored.
REQ-021 SHALL transmit each byte as 8 bits MSB first: mosi stable while sclk low, sclk high clk_div cycles, low clk_div cycles.
REQ-022 SHALL raise ss clk_div cycles before the first sclk rise of a transaction and drop it clk_div cycles after the last sclk fall.
REQ-023 Transaction 1 SHALL be byte 0xF0 followed by rows*columns*segments*3 data bytes with ss held high throughout.
REQ-024 Data order SHALL be row outer (0..rows-1), column inner (0..columns-1).
REQ-025 FETCH SHALL pulse ren for one cycle with rrow/rcol, then latch rdata into a shift word on the following cycle.
REQ-026 Each word SHALL be sent most significant byte first (bits [N-1:N-8] first, N=segments*24).
REQ-027 The next word SHALL be fetched only after the last byte of the current word completes; inter-byte gaps are permitted, sclk stays low during gaps.
REQ-028 After the last data byte of row rows-1, column columns-1, SHALL enter GAP with ss low for 4*clk_div cycles.
REQ-029 Transaction 2 SHALL be the single byte 0x10 with its own ss assertion.
REQ-030 FINISH SHALL pulse done for one cycle, clear busy, return to IDLE.
REQ-031 Address counters SHALL wrap to 0 after the final word; rrow/rcol SHALL hold their last value between reads.
REQ-032 busy SHALL be high from the cycle after start is accepted through the FINISH cycle.

Reset
REQ-033 On rst=0, SHALL immediately force IDLE, sclk=0, ss=0, mosi=0, ren=0, busy=0, done=0, rrow=0, rcol=0, regardless of transfer in progress.
REQ-034 After release mid-frame, SHALL send nothing until a new start.

Verification
REQ-035 segments=1, rows=2, columns=2, clk_div=2, rdata=addr-coded {row,col,0x5A}; start -> 0xF0 plus 12 bytes in row-major, MSB-byte-first order, ss low, then 0x10, done once.
REQ-036 Count sclk rises in transaction 1 = 8*(1+rows*columns*segments*3) and in transaction 2 = 8; each sclk high/low = clk_div cycles.
REQ-037 Drive start again while busy -> no effect; exactly one frame and one done pulse.
REQ-038 Assert rst low mid data byte -> same-cycle ss=0, sclk=0, busy=0; next start sends a full frame from row 0, col 0.
REQ-039 Loop mosi/sclk/ss into the team's SPI receiving display controller -> every framebuffer location written with matching data, loaded=1 after 0x10.
REQ-040 clk_div=1, segments=2 -> 6 bytes per word, ren spacing >= 48 sclk cycles, no bit glitches.
